mic_i2s_dac_tx: RTL

//  I2S transmitter driving the audio codec DAC data line (AUD_DACDAT); mirror of mic_system capture path.

---
 rtl/mic_audio_pkg.sv | 22 ++
 rtl/mic_sample_fifo.sv | 75 +++++++
 rtl/mic_i2s_dac_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mic_audio_pkg.sv
// Shared types and constants for the mic_system audio paths.
//   CH_W_DEF       default bits per channel
//   SYNC_STAGES    flops in each clock-domain-crossing synchroniser
//   stereo_word_t  {left, right} sample pair as carried on the stream
//   tx_state_e     I2S transmitter frame state
package mic_audio_pkg;

  localparam int unsigned CH_W_DEF    = 16;
  localparam int unsigned SYNC_STAGES = 2;

  typedef struct packed {
    logic [CH_W_DEF-1:0] left;
    logic [CH_W_DEF-1:0] right;
  } stereo_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/mic_sample_fifo.sv
// Synchronous FIFO holding stereo sample words between the stream input and
// the I2S serialiser.
//   clk_i, reset_i   clock, asynchronous active-high reset
//   push_i, wdata_i  write request / data (ignored when full)
//   pop_i            read request (ignored when empty)
//   rdata_o          head-of-queue word
//   level_o          words held; full_o / empty_o flags
module mic_sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_acc_c;
  logic             pop_acc_c;

  assign push_acc_c = push_i & ~full_q;
  assign pop_acc_c  = pop_i & ~empty_q;

  // Pointer/level bookkeeping; flags are precomputed so they come from flops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_acc_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push_acc_c) - LVL_W'(pop_acc_c);
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_acc_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/mic_i2s_dac_tx.sv
// I2S transmitter for the codec DAC line, slaved to codec-mastered BCLK/LRCK.
//   clk, reset            system clock (>= 8x bclk), async active-high reset
//   enable                transmit enable (level)
//   s_data/s_valid/s_ready  stereo word stream {left, right}
//   aud_bclk, aud_daclrck codec clocks (asynchronous); lrck 0 = left
//   aud_dacdat            serial data, MSB first, one bclk after LRCK edge
//   fifo_level            words buffered
//   underrun_cnt          saturating count of left frames started empty
//   frame_tick            one-clk pulse at each active left-frame start
module mic_i2s_dac_tx
  import mic_audio_pkg::*;
#(
  parameter int unsigned CH_W       = CH_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [2*CH_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          aud_bclk,
  input  logic                          aud_daclrck,
  output logic                          aud_dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              underrun_cnt,
  output logic                          frame_tick
);

  localparam int unsigned WORD_W = 2 * CH_W;
  localparam int unsigned BIT_W  = $clog2(CH_W + 1);

  // FIFO
  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_c;

  mic_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (s_valid),
    .wdata_i (s_data),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s_ready = ~fifo_full;

  // Synchronisers; bclk carries one extra stage for edge detection.
  logic [SYNC_STAGES:0]   bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic                   bclk_rise_c;
  logic                   bclk_fall_c;
  logic                   lrck_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-1:0], aud_bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], aud_daclrck};
    end
  end

  assign bclk_rise_c = bclk_sync_q[SYNC_STAGES-1] & ~bclk_sync_q[SYNC_STAGES];
  assign bclk_fall_c = ~bclk_sync_q[SYNC_STAGES-1] & bclk_sync_q[SYNC_STAGES];
  assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];

  // Frame state and serialiser
  tx_state_e         state_q, state_d;
  logic              lrck_smp_q, lrck_smp_d;
  logic              pend_q, pend_d;
  logic [CH_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic              dat_q, dat_d;
  logic [CH_W-1:0]   right_q, right_d;
  logic [CNT_W-1:0]  und_q, und_d;
  logic              tick_q, tick_d;
  logic              enter_left_c;
  logic              enter_right_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lrck_smp_q <= 1'b0;
      pend_q     <= 1'b0;
      shift_q    <= '0;
      bits_q     <= '0;
      dat_q      <= 1'b0;
      right_q    <= '0;
      und_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrck_smp_q <= lrck_smp_d;
      pend_q     <= pend_d;
      shift_q    <= shift_d;
      bits_q     <= bits_d;
      dat_q      <= dat_d;
      right_q    <= right_d;
      und_q      <= und_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lrck_smp_d    = lrck_smp_q;
    pend_d        = pend_q;
    shift_d       = shift_q;
    bits_d        = bits_q;
    dat_d         = dat_q;
    right_d       = right_q;
    und_d         = und_q;
    tick_d        = 1'b0;
    pop_c         = 1'b0;
    enter_left_c  = 1'b0;
    enter_right_c = 1'b0;

    // LRCK is judged only at bclk rises, the same instant the codec samples it.
    if (bclk_rise_c) begin
      lrck_smp_d = lrck_s;
      if (lrck_s != lrck_smp_q) begin
        case (state_q)
          ST_IDLE:  enter_left_c  = ~lrck_s & enable;
          ST_LEFT:  enter_right_c = lrck_s;
          ST_RIGHT: begin
            if (!lrck_s) begin
              if (enable) begin
                enter_left_c = 1'b1;
              end else begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                bits_d  = '0;
              end
            end
          end
          default:  state_d = ST_IDLE;
        endcase
      end
    end

    // New left frame: take a word, or count an underrun and send silence.
    if (enter_left_c) begin
      state_d = ST_LEFT;
      pend_d  = 1'b1;
      tick_d  = 1'b1;
      if (!fifo_empty) begin
        pop_c   = 1'b1;
        shift_d = fifo_rdata[WORD_W-1:CH_W];
        right_d = fifo_rdata[CH_W-1:0];
      end else begin
        shift_d = '0;
        right_d = '0;
        if (!(&und_q)) und_d = und_q + CNT_W'(1);
      end
    end

    if (enter_right_c) begin
      state_d = ST_RIGHT;
      pend_d  = 1'b1;
      shift_d = right_q;
    end

    // The first fall after a transition carries the MSB (one-bit I2S delay).
    if (bclk_fall_c) begin
      if (pend_q) begin
        dat_d   = shift_q[CH_W-1];
        shift_d = {shift_q[CH_W-2:0], 1'b0};
        bits_d  = BIT_W'(CH_W - 1);
        pend_d  = 1'b0;
      end else if (bits_q != '0) begin
        dat_d   = shift_q[CH_W-1];
        shift_d = {shift_q[CH_W-2:0], 1'b0};
        bits_d  = bits_q - BIT_W'(1);
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  assign aud_dacdat   = dat_q;
  assign underrun_cnt = und_q;
  assign frame_tick   = tick_q;

endmodule
